// File: rtl/imm_defs.sv
// Shared encodings for the immediate assembler: extension modes and FSM states.
package imm_defs;

  localparam logic [1:0] MODE_SIGN  = 2'b00;
  localparam logic [1:0] MODE_ZERO  = 2'b01;
  localparam logic [1:0] MODE_UPPER = 2'b10;
  localparam logic [1:0] MODE_RSVD  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ACCUM = 2'b01,
    S_OUT   = 2'b10
  } state_e;

endpackage

// File: rtl/imm_ext_unit.sv
// Combinational extender: widens the low cnt*CHUNK_W bits of acc to OUT_W bits
// by sign, zero or upper placement. Reusable by the branch-offset path.
module imm_ext_unit
  import imm_defs::*;
#(
  parameter int CHUNK_W    = 8,
  parameter int MAX_CHUNKS = 2,
  parameter int OUT_W      = 16,
  localparam int ACC_W     = CHUNK_W * MAX_CHUNKS,
  localparam int CNT_W     = $clog2(MAX_CHUNKS + 1)
) (
  input  logic [ACC_W-1:0] acc,
  input  logic [CNT_W-1:0] cnt,
  input  logic [1:0]       mode,
  output logic [OUT_W-1:0] ext,
  output logic             rsvd
);

  int               n;
  logic [OUT_W-1:0] acc_w;
  logic [OUT_W-1:0] mask;
  logic [OUT_W-1:0] sign_bit;
  logic [OUT_W-1:0] val;

  always_comb begin
    n             = int'(cnt) * CHUNK_W;
    acc_w         = '0;
    acc_w[ACC_W-1:0] = acc;
    // mask selects the n valid bits; sign_bit is the MSB of that field
    mask          = (n == 0) ? '0 : ({OUT_W{1'b1}} >> (OUT_W - n));
    sign_bit      = (n == 0) ? '0 : (OUT_W'(1) << (n - 1));
    val           = acc_w & mask;
    rsvd          = (mode == MODE_RSVD);
    case (mode)
      MODE_SIGN:  ext = val | (((val & sign_bit) != '0) ? ~mask : '0);
      MODE_UPPER: ext = (n == 0) ? '0 : (val << (OUT_W - n));
      default:    ext = val;
    endcase
  end

endmodule

// File: rtl/imm_builder.sv
// Sequential immediate assembler: collects MSB-first chunks, extends the result
// and presents it on a registered valid/ready output.
module imm_builder
  import imm_defs::*;
#(
  parameter int CHUNK_W    = 8,
  parameter int MAX_CHUNKS = 2,
  parameter int OUT_W      = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [CHUNK_W-1:0] in_chunk,
  input  logic               in_last,
  input  logic [1:0]         in_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OUT_W-1:0]   out_imm,
  output logic               out_err
);

  localparam int ACC_W = CHUNK_W * MAX_CHUNKS;
  localparam int CNT_W = $clog2(MAX_CHUNKS + 1);

  // Handshake: a transfer happens on a port in any cycle where its valid and
  // ready are both high; valid never depends on ready on the same port.
  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         mode_q, mode_d;
  logic [OUT_W-1:0]   out_imm_q, out_imm_d;
  logic               out_err_q, out_err_d;
  logic               accept;
  logic               first;
  logic               frame_end;
  logic [OUT_W-1:0]   ext;
  logic               rsvd;

  assign in_ready  = (state_q != S_OUT) || out_ready;
  assign accept    = in_valid && in_ready;
  assign first     = (state_q != S_ACCUM);
  assign out_valid = (state_q == S_OUT);
  assign out_imm   = out_imm_q;
  assign out_err   = out_err_q;

  // Next frame contents; the extender sees them so the result registers at frame end
  always_comb begin
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    mode_d = mode_q;
    if (accept) begin
      if (first) begin
        acc_d  = ACC_W'(in_chunk);
        cnt_d  = CNT_W'(1);
        mode_d = in_mode;
      end else begin
        acc_d  = (acc_q << CHUNK_W) | ACC_W'(in_chunk);
        cnt_d  = cnt_q + 1'b1;
      end
    end
  end

  imm_ext_unit #(
    .CHUNK_W   (CHUNK_W),
    .MAX_CHUNKS(MAX_CHUNKS),
    .OUT_W     (OUT_W)
  ) u_ext (
    .acc (acc_d),
    .cnt (cnt_d),
    .mode(mode_d),
    .ext (ext),
    .rsvd(rsvd)
  );

  always_comb begin
    state_d   = state_q;
    out_imm_d = out_imm_q;
    out_err_d = out_err_q;
    frame_end = accept && (in_last || (cnt_d == CNT_W'(MAX_CHUNKS)));
    if (state_q == S_OUT && out_ready) state_d = S_IDLE;
    if (accept) begin
      if (frame_end) begin
        state_d   = S_OUT;
        out_imm_d = ext;
        out_err_d = rsvd || !in_last;
      end else begin
        state_d   = S_ACCUM;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      mode_q    <= MODE_SIGN;
      out_imm_q <= '0;
      out_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      mode_q    <= mode_d;
      out_imm_q <= out_imm_d;
      out_err_q <= out_err_d;
    end
  end

endmodule

// File: tb/tb_imm_builder.sv
// Bench for imm_builder in the 8/16/2 configuration: directed scenarios plus a
// randomized run against a frame-level reference model.
module tb_imm_builder;

  localparam int CHUNK_W    = 8;
  localparam int MAX_CHUNKS = 2;
  localparam int OUT_W      = 16;

  logic               clk;
  logic               reset;
  logic               in_valid;
  logic               in_ready;
  logic [CHUNK_W-1:0] in_chunk;
  logic               in_last;
  logic [1:0]         in_mode;
  logic               out_valid;
  logic               out_ready;
  logic [OUT_W-1:0]   out_imm;
  logic               out_err;

  int n_cmp = 0;
  int n_bad = 0;

  imm_builder #(
    .CHUNK_W   (CHUNK_W),
    .MAX_CHUNKS(MAX_CHUNKS),
    .OUT_W     (OUT_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_chunk (in_chunk),
    .in_last  (in_last),
    .in_mode  (in_mode),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_imm  (out_imm),
    .out_err  (out_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: value of k chunks (MSB-first) extended to OUT_W by plain arithmetic
  function automatic logic [OUT_W-1:0] ref_imm(input longint val, input int k,
                                               input logic [1:0] mode);
    longint n;
    longint r;
    n = longint'(k) * CHUNK_W;
    if (mode == 2'b10)
      r = val * (longint'(1) << (OUT_W - n));
    else if (mode == 2'b00 && val >= (longint'(1) << (n - 1)))
      r = val - (longint'(1) << n) + (longint'(1) << OUT_W);
    else
      r = val;
    return OUT_W'(r);
  endfunction

  // driver tasks: present one chunk for a single edge, leave time at edge+1
  task automatic drive(input logic [7:0] ch, input logic last, input logic [1:0] mode);
    in_valid = 1'b1;
    in_chunk = ch;
    in_last  = last;
    in_mode  = mode;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_cycle();
    idle_cycle();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (out_valid !== 1'b0 || out_imm !== 16'h0000 || out_err !== 1'b0 || in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset: valid=%b imm=%h err=%b rdy=%b want 0/0000/0/1",
               out_valid, out_imm, out_err, in_ready);
    end
  endtask

  task automatic test_single(input logic [7:0] ch, input logic [1:0] mode, input string nm);
    logic [OUT_W-1:0] exp;
    exp = ref_imm(longint'(ch), 1, mode);
    out_ready = 1'b1;
    drive(ch, 1'b1, mode);
    n_cmp++;
    if (out_valid !== 1'b1 || out_imm !== exp || out_err !== (mode == 2'b11)) begin
      n_bad++;
      $display("FAIL %s: valid=%b imm=%h err=%b want 1/%h/%b", nm, out_valid, out_imm,
               out_err, exp, (mode == 2'b11));
    end
    idle_cycle();
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL %s_drain: valid=%b want 0", nm, out_valid);
    end
  endtask

  task automatic test_two_chunk(input logic [7:0] c0, input logic [7:0] c1,
                                input logic [1:0] mode, input string nm);
    logic [OUT_W-1:0] exp;
    exp = ref_imm(longint'(c0) * 256 + longint'(c1), 2, mode);
    out_ready = 1'b1;
    drive(c0, 1'b0, mode);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL %s_partial: valid=%b want 0", nm, out_valid);
    end
    drive(c1, 1'b1, 2'b10);  // mode on a later chunk must be ignored
    n_cmp++;
    if (out_valid !== 1'b1 || out_imm !== exp || out_err !== 1'b0) begin
      n_bad++;
      $display("FAIL %s: valid=%b imm=%h err=%b want 1/%h/0", nm, out_valid, out_imm, out_err, exp);
    end
    idle_cycle();
  endtask

  task automatic test_truncation();
    out_ready = 1'b1;
    drive(8'h12, 1'b0, 2'b01);
    drive(8'h34, 1'b0, 2'b01);
    n_cmp++;
    if (out_valid !== 1'b1 || out_imm !== 16'h1234 || out_err !== 1'b1) begin
      n_bad++;
      $display("FAIL trunc: valid=%b imm=%h err=%b want 1/1234/1", out_valid, out_imm, out_err);
    end
    drive(8'h56, 1'b0, 2'b01);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL trunc_newframe: valid=%b want 0", out_valid);
    end
    drive(8'h78, 1'b1, 2'b00);
    n_cmp++;
    if (out_valid !== 1'b1 || out_imm !== 16'h5678 || out_err !== 1'b0) begin
      n_bad++;
      $display("FAIL trunc_next: valid=%b imm=%h err=%b want 1/5678/0", out_valid, out_imm, out_err);
    end
    idle_cycle();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    drive(8'hFF, 1'b1, 2'b01);
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (out_valid !== 1'b1 || out_imm !== 16'h00FF || out_err !== 1'b0 || in_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL stall%0d: valid=%b imm=%h err=%b rdy=%b want 1/00ff/0/0",
                 i, out_valid, out_imm, out_err, in_ready);
      end
      idle_cycle();
    end
    out_ready = 1'b1;
    drive(8'h01, 1'b1, 2'b01);
    n_cmp++;
    if (out_valid !== 1'b1 || out_imm !== 16'h0001 || out_err !== 1'b0) begin
      n_bad++;
      $display("FAIL stall_release: valid=%b imm=%h err=%b want 1/0001/0", out_valid, out_imm, out_err);
    end
    idle_cycle();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    drive(8'h12, 1'b0, 2'b01);
    reset = 1'b1;
    idle_cycle();
    reset = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || out_imm !== 16'h0000 || out_err !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid: valid=%b imm=%h err=%b want 0/0000/0", out_valid, out_imm, out_err);
    end
    drive(8'h34, 1'b1, 2'b01);
    n_cmp++;
    if (out_valid !== 1'b1 || out_imm !== 16'h0034 || out_err !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid_next: valid=%b imm=%h err=%b want 1/0034/0", out_valid, out_imm, out_err);
    end
    idle_cycle();
  endtask

  task automatic test_back_to_back();
    logic [OUT_W-1:0] exp_q[$];
    logic [7:0]       ch;
    logic [1:0]       md;
    logic [OUT_W-1:0] e;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_last   = 1'b1;
    for (int i = 0; i < 12; i++) begin
      ch = 8'($urandom_range(0, 255));
      md = 2'($urandom_range(0, 2));
      in_chunk = ch;
      in_mode  = md;
      exp_q.push_back(ref_imm(longint'(ch), 1, md));
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      n_cmp++;
      if (out_valid !== 1'b1 || out_imm !== e || out_err !== 1'b0) begin
        n_bad++;
        $display("FAIL b2b%0d: valid=%b imm=%h err=%b want 1/%h/0", i, out_valid, out_imm, out_err, e);
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    idle_cycle();
  endtask

  // Frame-level model: partial frame value/length, plus at most one pending result
  task automatic test_random();
    longint           f_val;
    int               f_len;
    logic [1:0]       f_mode;
    logic             pend;
    logic [OUT_W-1:0] p_imm;
    logic             p_err;
    logic             acc_now;
    do_reset();
    f_val = 0; f_len = 0; f_mode = 2'b00; pend = 1'b0; p_imm = '0; p_err = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      n_cmp++;
      if (out_valid !== pend || in_ready !== (!pend || out_ready) ||
          (pend && (out_imm !== p_imm || out_err !== p_err))) begin
        n_bad++;
        $display("FAIL rand%0d: valid=%b imm=%h err=%b rdy=%b want %b/%h/%b/%b", cyc,
                 out_valid, out_imm, out_err, in_ready, pend, p_imm, p_err, (!pend || out_ready));
      end
      in_valid  = ($urandom_range(0, 3) != 0);
      in_chunk  = 8'($urandom_range(0, 255));
      in_last   = ($urandom_range(0, 2) == 0);
      in_mode   = 2'($urandom_range(0, 3));
      out_ready = ($urandom_range(0, 2) != 0);
      acc_now   = in_valid && (!pend || out_ready);
      if (pend && out_ready) pend = 1'b0;
      if (acc_now) begin
        if (f_len == 0) f_mode = in_mode;
        f_val = f_val * 256 + longint'(in_chunk);
        f_len++;
        if (in_last || f_len == MAX_CHUNKS) begin
          pend  = 1'b1;
          p_imm = ref_imm(f_val, f_len, f_mode);
          p_err = (f_mode == 2'b11) || !in_last;
          f_val = 0;
          f_len = 0;
        end
      end
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    idle_cycle();
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_chunk  = '0;
    in_last   = 1'b0;
    in_mode   = 2'b00;
    out_ready = 1'b0;
    test_reset();
    test_single(8'h80, 2'b00, "sign_80");
    test_two_chunk(8'h12, 8'h34, 2'b01, "zero_1234");
    test_two_chunk(8'hF2, 8'h34, 2'b00, "sign_f234");
    test_single(8'hAB, 2'b10, "upper_ab");
    test_single(8'h80, 2'b11, "rsvd_80");
    test_single(8'h7F, 2'b00, "sign_7f");
    test_truncation();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
